// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
//   SZ_*  : request size encodings carried on req_size.
//   S_*   : FSM state encodings.
//   misaligned(): misalignment / reserved-size classification, used only when
//                 LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lo[0];
            SZ_WORD: m = (lo != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   word      in  32  memory word (fresh mem_q during read wait, captured word otherwise)
//   lane      in  2   byte address bits [1:0]
//   size      in  2   request size (byte/half/word; reserved behaves as word)
//   sext      in  1   sign-extend loads
//   wdata     in  32  right-justified store data
//   load_data out 32  selected lane, sign/zero extended
//   merged    out 32  word with the store lane(s) replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    // Little-endian: lane 0 is word[7:0]; half lane chosen by lane[1] only.
    assign bsel = 8'(word >> {lane, 3'b000});
    assign hsel = 16'(word >> {lane[1], 4'b0000});

    always_comb begin
        load_data = word;
        merged    = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sext & bsel[7]}}, bsel};
                merged    = word;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sext & hsel[15]}}, hsel};
                merged    = word;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage front end for a single-port sync-read data memory.
// Accepts byte/half/word loads and stores, issues word accesses, extends load
// data and performs read-modify-write for sub-word stores.
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   req_valid/req_ready       request handshake (accepted only when idle)
//   req_we/size/signed/addr/wdata  request fields (byte address)
//   rsp_valid/rsp_rdata/rsp_error  one-cycle completion pulse and result
//   mem_address/mem_data/mem_wren/mem_q  data memory interface
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned or
// reserved-size requests with rsp_error and skip the memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    localparam logic [1:0] LAST_CNT = 2'(MEM_RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       data_q;
    logic              acc_err;
    logic              err_flag;
    logic [31:0]       align_word;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              acc_word;

    assign acc_word = (req_size == SZ_WORD) || (req_size == SZ_RSVD);

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign acc_err  = misaligned(req_size, req_addr[1:0]);
    assign err_flag = err_q;
`else
    assign acc_err  = 1'b0;
    assign err_flag = 1'b0;
`endif

    // The fresh memory word feeds the merge at the end of the read wait; the
    // captured word feeds load extraction in RESP.
    assign align_word = (state == S_RD_WAIT) ? mem_q : word_q;

    lsu_align u_align (
        .word      (align_word),
        .lane      (addr_q[1:0]),
        .size      (size_q),
        .sext      (sext_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            data_q  <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sext_q  <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= 2'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                        err_q   <= acc_err;
`endif
                        if (acc_err) begin
                            state <= S_RESP;
                        end else if (req_we && acc_word) begin
                            data_q <= req_wdata;
                            state  <= S_WRITE;
                        end else begin
                            state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == LAST_CNT) begin
                        word_q <= mem_q;
                        data_q <= merged;
                        state  <= we_q ? S_WRITE : S_RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    // In IDLE the address goes straight from the request so the memory samples
    // it on the accepting edge; afterwards the latched address is held.
    assign mem_address = (state != S_IDLE) ? addr_q[ADDR_W+1:2] :
                         (req_valid ? req_addr[ADDR_W+1:2] : '0);
    assign mem_data    = data_q;
    assign mem_wren    = (state == S_WRITE);
    assign req_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign rsp_error   = (state == S_RESP) && err_flag;
    assign rsp_rdata   = ((state == S_RESP) && !we_q && !err_flag) ? load_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [9:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    load_store_unit #(.ADDR_W(10), .MEM_RD_LAT(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // datamemory model: 1024x32, registered read, one cycle latency
    logic [31:0] mem [1024];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    // Issue one request at a negedge and check the full response.
    task automatic run_req(input vec_t t, input string tag);
        int lat;
        int wr;
        int busy_ready;
        logic got;
        logic [31:0] rd;
        logic er;
        logic [9:0] waddr;
        logic [31:0] wdat;
        lat = 0; wr = 0; busy_ready = 0; got = 1'b0; rd = 32'd0; er = 1'b0;
        waddr = '0; wdat = 32'd0;
        check({tag, " ready_before"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = t.we;
        req_size   = t.size;
        req_signed = t.sgn;
        req_addr   = t.addr;
        req_wdata  = t.wdata;
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (lat < 20 && !got) begin
            @(negedge clock);
            lat++;
            if (req_ready) busy_ready++;
            if (mem_wren) begin
                wr++;
                waddr = mem_address;
                wdat  = mem_data;
            end
            if (rsp_valid) begin
                got = 1'b1;
                rd  = rsp_rdata;
                er  = rsp_error;
            end
        end
        check({tag, " rsp_seen"}, {31'd0, got}, 32'd1);
        check({tag, " rdata"}, rd, t.rdata);
        check({tag, " error"}, {31'd0, er}, {31'd0, t.err});
        check({tag, " latency"}, lat, t.lat);
        check({tag, " ready_busy"}, busy_ready, 0);
        check({tag, " wren_cycles"}, wr, (t.we && !t.err) ? 1 : 0);
        if (wr != 0) begin
            check({tag, " wren_addr"}, {22'd0, waddr}, {22'd0, t.addr[11:2]});
        end
        @(negedge clock);
        check({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
        check({tag, " rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " rsp_error"}, {31'd0, rsp_error}, 32'd0);
        check({tag, " mem_wren"}, {31'd0, mem_wren}, 32'd0);
        check({tag, " mem_address"}, {22'd0, mem_address}, 32'd0);
        check({tag, " mem_data"}, mem_data, 32'd0);
    endtask

    vec_t v[15];
    vec_t rv;
    logic wren_seen;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 12'd0; req_wdata = 32'd0;

        //        we    size   sgn   addr     wdata         rdata         err   lat
        v[0]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
        v[1]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        v[2]  = '{1'b1, 2'b00, 1'b0, 12'h011, 32'h0000005A, 32'h00000000, 1'b0, 3};
        v[3]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEAD5AEF, 1'b0, 2};
        v[4]  = '{1'b0, 2'b00, 1'b1, 12'h011, 32'h0,        32'h0000005A, 1'b0, 2};
        v[5]  = '{1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 2};
        v[6]  = '{1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        32'h000000DE, 1'b0, 2};
        v[7]  = '{1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 2};
        v[8]  = '{1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        32'h0000DEAD, 1'b0, 2};
        v[9]  = '{1'b1, 2'b01, 1'b0, 12'h012, 32'hFFFF1234, 32'h00000000, 1'b0, 3};
        v[10] = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h12345AEF, 1'b0, 2};
`ifdef LSU_MISALIGN_TRAP_EN
        v[11] = '{1'b0, 2'b10, 1'b0, 12'h013, 32'h0,        32'h00000000, 1'b1, 1};
        v[12] = '{1'b0, 2'b01, 1'b1, 12'h011, 32'h0,        32'h00000000, 1'b1, 1};
`else
        v[11] = '{1'b0, 2'b10, 1'b0, 12'h013, 32'h0,        32'h12345AEF, 1'b0, 2};
        v[12] = '{1'b0, 2'b01, 1'b1, 12'h011, 32'h0,        32'h00005AEF, 1'b0, 2};
`endif
        v[13] = '{1'b1, 2'b10, 1'b0, 12'hFFC, 32'hCAFEF00D, 32'h00000000, 1'b0, 2};
        v[14] = '{1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 2};

        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 15; i++) begin
            run_req(v[i], $sformatf("v%0d", i));
        end

        // Reset during the read wait of a byte store: the merge write must be dropped.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 12'h010; req_wdata = 32'h00000077;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rst ready_low_in_wait", {31'd0, req_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        wren_seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (mem_wren) wren_seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (mem_wren) wren_seen = 1'b1;
        end
        check("rst wren_never", {31'd0, wren_seen}, 32'd0);
        check("rst ready_after", {31'd0, req_ready}, 32'd1);
        rv = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h12345AEF, 1'b0, 2};
        run_req(rv, "rst_load");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
